frame_read_sequencer: RTL and testbench

Controls the pseudo-sensor capture chain. On each frame swap of the dual-BRAM pixel store, it streams the frozen core-side frame out of the BRAM at one pixel per clock into maxpool20x20. It then waits for the quantize stage to report end of frame and hands a "frame ready" pulse plus the image number to the LeNet-5 core. It replaces the free-running testbench reader. It also adds abort, drop accounting and a drain watchdog.

---
 rtl/frame_read_sequencer_pkg.sv | 27 ++
 rtl/frame_read_sequencer_if.sv | 42 ++++
 rtl/frame_read_sequencer_rd_lat_pipe.sv | 36 +++
 rtl/frame_read_sequencer.sv | 171 +++++++++++++++++
 tb/tb_frame_read_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_read_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_seq_pkg: shared state type, default geometry and drop-counter limit.
// Rev 1.0
// ----------------------------------------------------------------------------
package frame_seq_pkg;

  localparam int F_SIZE_DEF     = 307200;
  localparam int ADDR_FRAME_DEF = 19;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [7:0] DROP_SAT = 8'd255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == DROP_SAT) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_read_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_read_sequencer_if: BRAM, maxpool, quantize and CNN-side signals.
// Rev 1.0
// ----------------------------------------------------------------------------
interface frame_read_sequencer_if
  import frame_seq_pkg::*;
#(
  parameter int ADDR_FRAME = ADDR_FRAME_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  run_i;
  logic                  swap_c_i;
  logic [3:0]            image_num_c_i;
  logic [DATA_WIDTH-1:0] dout_c_i;
  logic [ADDR_FRAME-1:0] addr_c_o;
  logic                  pix_valid_o;
  logic [DATA_WIDTH-1:0] pix_o;
  logic                  pipe_srst_o;
  logic                  q_frame_last_i;
  logic                  cnn_ready_i;
  logic                  frame_rdy_o;
  logic [3:0]            frame_img_o;
  logic                  busy_o;
  logic [7:0]            drop_cnt_o;
  logic                  err_timeout_o;

  modport master (
    input  run_i, swap_c_i, image_num_c_i, dout_c_i, q_frame_last_i, cnn_ready_i,
    output addr_c_o, pix_valid_o, pix_o, pipe_srst_o, frame_rdy_o, frame_img_o,
           busy_o, drop_cnt_o, err_timeout_o
  );

  modport slave (
    output run_i, swap_c_i, image_num_c_i, dout_c_i, q_frame_last_i, cnn_ready_i,
    input  addr_c_o, pix_valid_o, pix_o, pipe_srst_o, frame_rdy_o, frame_img_o,
           busy_o, drop_cnt_o, err_timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/frame_read_sequencer_rd_lat_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_lat_pipe: valid shift register aligning pixel strobes with BRAM data.
// Rev 1.0
// ----------------------------------------------------------------------------
module rd_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_in_100,
  input  logic arst_n,
  input  logic flush,
  input  logic in_valid,
  output logic data_en,
  output logic out_valid,
  output logic busy
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      stages <= '0;
    end else if (flush) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], in_valid};
    end
  end

  // Next-to-last stage marks the cycle the BRAM presents the matching data.
  assign data_en   = stages[DEPTH-2];
  assign out_valid = stages[DEPTH-1];
  assign busy      = |stages;

endmodule
`default_nettype wire

// File: rtl/frame_read_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_read_sequencer: streams each frozen BRAM frame into maxpool and
// signals the CNN once quantize reports end of frame. Rev 1.0
// ----------------------------------------------------------------------------
module frame_read_sequencer
  import frame_seq_pkg::*;
#(
  parameter int F_SIZE        = F_SIZE_DEF,
  parameter int ADDR_FRAME    = ADDR_FRAME_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int READ_LAT      = 1,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                   clk_in_100,
  input  logic                   arst_n,
  frame_read_sequencer_if.master bus
);

  localparam int                    WD_W      = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ADDR_FRAME-1:0] LAST_ADDR = ADDR_FRAME'(F_SIZE - 1);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(DRAIN_TIMEOUT - 1);

  seq_state_t            state;
  logic                  swap_q;
  logic [ADDR_FRAME-1:0] addr;
  logic [WD_W-1:0]       wd_cnt;
  logic                  abort_cnt;
  logic [3:0]            frame_img;
  logic                  frame_rdy;
  logic                  busy;
  logic [7:0]            drop_cnt;
  logic                  err_timeout;
  logic                  pipe_srst;
  logic [DATA_WIDTH-1:0] pix;

  logic swap_rise;
  logic in_frame;
  logic drain_done;
  logic timeout_hit;
  logic abort_req;
  logic drop_evt;
  logic issue;
  logic flush;
  logic pix_load;
  logic pix_valid;
  logic pipe_busy;

  assign swap_rise   = bus.swap_c_i & ~swap_q;
  assign in_frame    = (state == READ) || (state == DRAIN);
  assign drain_done  = bus.q_frame_last_i && !pipe_busy;
  assign timeout_hit = (state == DRAIN) && bus.run_i && !drain_done && (wd_cnt == WD_LAST);
  assign abort_req   = (in_frame && !bus.run_i) || timeout_hit;
  assign drop_evt    = swap_rise &&
                       (in_frame || ((state == IDLE) && bus.run_i && !bus.cnn_ready_i));
  assign issue       = (state == READ);
  // Flushing on the abort decision itself kills pix_valid on the same edge.
  assign flush       = abort_req || (state == ABORT);

  rd_lat_pipe #(
    .DEPTH (READ_LAT + 1)
  ) u_rd_lat_pipe (
    .clk_in_100 (clk_in_100),
    .arst_n     (arst_n),
    .flush      (flush),
    .in_valid   (issue),
    .data_en    (pix_load),
    .out_valid  (pix_valid),
    .busy       (pipe_busy)
  );

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      swap_q      <= 1'b0;
      addr        <= '0;
      wd_cnt      <= '0;
      abort_cnt   <= 1'b0;
      frame_img   <= 4'd0;
      frame_rdy   <= 1'b0;
      busy        <= 1'b0;
      drop_cnt    <= 8'd0;
      err_timeout <= 1'b0;
      pipe_srst   <= 1'b1;
    end else begin
      frame_rdy <= 1'b0;
      pipe_srst <= 1'b0;
      // A rise seen in DONE/ABORT stays pending so IDLE evaluates it next.
      if (!(swap_rise && ((state == DONE) || (state == ABORT)))) begin
        swap_q <= bus.swap_c_i;
      end
      if (drop_evt) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
      case (state)
        IDLE: begin
          if (swap_rise && bus.run_i && bus.cnn_ready_i) begin
            state     <= READ;
            addr      <= '0;
            frame_img <= bus.image_num_c_i;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (abort_req) begin
            state     <= ABORT;
            abort_cnt <= 1'b0;
            pipe_srst <= 1'b1;
          end else if (addr == LAST_ADDR) begin
            state  <= DRAIN;
            wd_cnt <= '0;
          end else begin
            addr <= addr + ADDR_FRAME'(1);
          end
        end
        DRAIN: begin
          if (abort_req) begin
            state     <= ABORT;
            abort_cnt <= 1'b0;
            pipe_srst <= 1'b1;
            if (timeout_hit) begin
              err_timeout <= 1'b1;
            end
          end else if (drain_done) begin
            state     <= DONE;
            frame_rdy <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ABORT: begin
          if (abort_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            abort_cnt <= 1'b1;
            pipe_srst <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      pix <= '0;
    end else if (pix_load) begin
      pix <= bus.dout_c_i;
    end
  end

  assign bus.addr_c_o      = addr;
  assign bus.pix_valid_o   = pix_valid;
  assign bus.pix_o         = pix;
  assign bus.pipe_srst_o   = pipe_srst;
  assign bus.frame_rdy_o   = frame_rdy;
  assign bus.frame_img_o   = frame_img;
  assign bus.busy_o        = busy;
  assign bus.drop_cnt_o    = drop_cnt;
  assign bus.err_timeout_o = err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_frame_read_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_read_sequencer: randomized frames against a transaction-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_frame_read_sequencer;

  localparam int F_SIZE        = 1200;
  localparam int ADDR_FRAME    = 11;
  localparam int DATA_WIDTH    = 8;
  localparam int READ_LAT      = 1;
  localparam int DRAIN_TIMEOUT = 64;

  logic clk_in_100 = 1'b0;
  logic arst_n     = 1'b0;
  always #5 clk_in_100 = ~clk_in_100;

  frame_read_sequencer_if #(.ADDR_FRAME(ADDR_FRAME), .DATA_WIDTH(DATA_WIDTH)) bus ();

  frame_read_sequencer #(
    .F_SIZE        (F_SIZE),
    .ADDR_FRAME    (ADDR_FRAME),
    .DATA_WIDTH    (DATA_WIDTH),
    .READ_LAT      (READ_LAT),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .clk_in_100 (clk_in_100),
    .arst_n     (arst_n),
    .bus        (bus)
  );

  // Frozen frame content: pixel at address a is a[7:0] xor a per-frame salt.
  logic [7:0] bram_salt = 8'd0;
  logic [DATA_WIDTH-1:0] rd_sh [READ_LAT];

  function automatic logic [7:0] bram_data(input int a);
    return 8'(a) ^ bram_salt;
  endfunction

  always @(posedge clk_in_100) begin
    rd_sh[0] <= bram_data(int'(bus.addr_c_o));
    for (int i = 1; i < READ_LAT; i++) rd_sh[i] <= rd_sh[i-1];
  end
  assign bus.dout_c_i = rd_sh[READ_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe, pix_bad, gaps, first_cyc, n_rdy, n_srst;
  bit prev_v;
  int exp_drop = 0;
  bit exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int drop_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic clear_mon();
    n_strobe = 0; pix_bad = 0; gaps = 0; first_cyc = -1;
    n_rdy = 0; n_srst = 0; prev_v = 1'b0;
  endtask

  // One clock; outputs sampled 1 ns after the edge. The n-th strobe of a frame must carry pixel n.
  task automatic step();
    @(posedge clk_in_100);
    #1;
    cyc++;
    if (bus.pix_valid_o) begin
      if (bus.pix_o !== bram_data(n_strobe)) pix_bad++;
      if (n_strobe > 0 && !prev_v) gaps++;
      if (n_strobe == 0) first_cyc = cyc;
      n_strobe++;
    end
    prev_v = bus.pix_valid_o;
    if (bus.frame_rdy_o) n_rdy++;
    if (bus.pipe_srst_o) n_srst++;
  endtask

  task automatic start_frame(input logic [3:0] img, output int c0);
    bram_salt = 8'($urandom);
    bus.image_num_c_i = img;
    bus.run_i = 1'b1;
    bus.cnn_ready_i = 1'b1;
    clear_mon();
    bus.swap_c_i = 1'b1;
    step();
    bus.swap_c_i = 1'b0;
    c0 = cyc;
    check_eq("start_busy", 32'(bus.busy_o), 32'd1);
    check_eq("start_addr", 32'(bus.addr_c_o), 32'd0);
  endtask

  task automatic wait_strobes(input bit late, input int c0);
    int guard = 0;
    while (!(n_strobe >= F_SIZE && !prev_v) && guard < F_SIZE + 40) begin
      bus.swap_c_i = late && (guard == 300);
      step();
      guard++;
    end
    bus.swap_c_i = 1'b0;
    if (late) exp_drop = drop_inc(exp_drop);
    check_eq("stream_bound", 32'(guard < F_SIZE + 40), 32'd1);
    check_eq("first_latency", 32'(first_cyc - c0), 32'(READ_LAT + 1));
    check_eq("strobe_count", 32'(n_strobe), 32'(F_SIZE));
    check_eq("strobe_gaps", 32'(gaps), 32'd0);
    check_eq("pix_data_bad", 32'(pix_bad), 32'd0);
  endtask

  task automatic run_frame(input logic [3:0] img, input bit late, input bit chain_in, input bit chain_out);
    int c0;
    int qd;
    if (chain_in) begin
      // Swap already rose during the previous frame's DONE cycle.
      bram_salt = 8'($urandom);
      bus.image_num_c_i = img;
      clear_mon();
      step();
      check_eq("chain_idle", {30'd0, bus.busy_o, bus.frame_rdy_o}, 32'd0);
      step();
      bus.swap_c_i = 1'b0;
      c0 = cyc;
      check_eq("chain_busy", 32'(bus.busy_o), 32'd1);
      check_eq("chain_addr", 32'(bus.addr_c_o), 32'd0);
    end else begin
      start_frame(img, c0);
    end
    wait_strobes(late, c0);
    qd = $urandom_range(3, 30);
    for (int j = 0; j < qd; j++) begin
      bus.swap_c_i = late && (j == 0);
      step();
    end
    bus.swap_c_i = 1'b0;
    if (late) exp_drop = drop_inc(exp_drop);
    check_eq("drain_busy", 32'(bus.busy_o), 32'd1);
    check_eq("drain_no_rdy", 32'(n_rdy), 32'd0);
    bus.q_frame_last_i = 1'b1;
    step();
    bus.q_frame_last_i = 1'b0;
    check_eq("rdy_pulse", 32'(bus.frame_rdy_o), 32'd1);
    check_eq("rdy_img", 32'(bus.frame_img_o), 32'(img));
    check_eq("drop_cnt", 32'(bus.drop_cnt_o), 32'(exp_drop));
    check_eq("err_flag", 32'(bus.err_timeout_o), 32'(exp_err));
    if (chain_out) begin
      bus.swap_c_i = 1'b1;
    end else begin
      step();
      check_eq("rdy_end", 32'(bus.frame_rdy_o), 32'd0);
      check_eq("busy_end", 32'(bus.busy_o), 32'd0);
      check_eq("rdy_once", 32'(n_rdy), 32'd1);
    end
  endtask

  initial begin
    int c0;
    int at;
    int c_err;
    int guard;
    bit chain;
    bus.run_i = 1'b0;
    bus.swap_c_i = 1'b0;
    bus.image_num_c_i = 4'd0;
    bus.q_frame_last_i = 1'b0;
    bus.cnn_ready_i = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk_in_100);
    #1;
    check_eq("rst_srst", 32'(bus.pipe_srst_o), 32'd1);
    check_eq("rst_outs", {bus.addr_c_o, bus.pix_valid_o, bus.pix_o, bus.frame_rdy_o, bus.frame_img_o, bus.busy_o, bus.err_timeout_o}, 32'd0);
    check_eq("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
    arst_n = 1'b1;
    #1;
    check_eq("rst_srst_hold", 32'(bus.pipe_srst_o), 32'd1);
    step();
    check_eq("rst_srst_release", 32'(bus.pipe_srst_o), 32'd0);

    // Swap while CNN not ready: dropped, no read
    bus.run_i = 1'b1;
    bus.swap_c_i = 1'b1;
    step();
    bus.swap_c_i = 1'b0;
    step();
    exp_drop = drop_inc(exp_drop);
    check_eq("notready_busy", 32'(bus.busy_o), 32'd0);
    check_eq("notready_drop", 32'(bus.drop_cnt_o), 32'(exp_drop));

    // Nominal frames, including late swaps and a swap landing in DONE
    chain = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bit late;
      bit chain_out;
      late = (n == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      chain_out = (n == 1);
      run_frame(4'($urandom), late, chain, chain_out);
      chain = chain_out;
    end

    // Abort by dropping run mid-frame
    at = $urandom_range(100, 1150);
    start_frame(4'($urandom), c0);
    for (int i = 0; i < at; i++) step();
    check_eq("abort_addr", 32'(bus.addr_c_o), 32'(at));
    bus.run_i = 1'b0;
    step();
    check_eq("abort_valid_off", 32'(bus.pix_valid_o), 32'd0);
    check_eq("abort_srst1", 32'(bus.pipe_srst_o), 32'd1);
    step();
    check_eq("abort_srst2", 32'(bus.pipe_srst_o), 32'd1);
    step();
    check_eq("abort_srst_end", 32'(bus.pipe_srst_o), 32'd0);
    check_eq("abort_idle", 32'(bus.busy_o), 32'd0);
    repeat (8) step();
    check_eq("abort_no_rdy", 32'(n_rdy), 32'd0);
    check_eq("abort_srst_len", 32'(n_srst), 32'd2);
    check_eq("abort_strobes", 32'(n_strobe), 32'(at - READ_LAT));
    check_eq("abort_pix_bad", 32'(pix_bad), 32'd0);

    // Swap with run low is ignored entirely
    bus.swap_c_i = 1'b1;
    step();
    bus.swap_c_i = 1'b0;
    step();
    check_eq("norun_busy", 32'(bus.busy_o), 32'd0);
    check_eq("norun_drop", 32'(bus.drop_cnt_o), 32'(exp_drop));

    // Drain watchdog: quantize never reports end of frame
    start_frame(4'($urandom), c0);
    wait_strobes(1'b0, c0);
    guard = 0;
    while (!bus.err_timeout_o && guard < 200) begin
      step();
      guard++;
    end
    c_err = cyc;
    exp_err = 1'b1;
    check_eq("wd_flag", 32'(bus.err_timeout_o), 32'd1);
    check_eq("wd_latency", 32'(c_err - c0), 32'(F_SIZE + DRAIN_TIMEOUT));
    check_eq("wd_srst", 32'(bus.pipe_srst_o), 32'd1);
    step();
    step();
    check_eq("wd_idle", {30'd0, bus.busy_o, bus.pipe_srst_o}, 32'd0);
    check_eq("wd_no_rdy", 32'(n_rdy), 32'd0);

    // Normal frame after timeout: error flag stays set
    run_frame(4'($urandom), 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    start_frame(4'($urandom), c0);
    repeat (500) step();
    #2 arst_n = 1'b0;
    #1;
    exp_drop = 0;
    exp_err = 1'b0;
    check_eq("arst_outs", {bus.addr_c_o, bus.pix_valid_o, bus.busy_o, bus.err_timeout_o, bus.frame_rdy_o}, 32'd0);
    check_eq("arst_drop", 32'(bus.drop_cnt_o), 32'd0);
    check_eq("arst_srst", 32'(bus.pipe_srst_o), 32'd1);
    #2 arst_n = 1'b1;
    step();
    check_eq("arst_srst_release", 32'(bus.pipe_srst_o), 32'd0);
    run_frame(4'($urandom), 1'b0, 1'b0, 1'b0);

    // Drop counter saturation
    bus.cnn_ready_i = 1'b0;
    bus.run_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.swap_c_i = 1'b1;
      step();
      bus.swap_c_i = 1'b0;
      step();
      exp_drop = drop_inc(exp_drop);
      if (i == 199) check_eq("drop_mid", 32'(bus.drop_cnt_o), 32'(exp_drop));
    end
    check_eq("drop_sat", 32'(bus.drop_cnt_o), 32'(exp_drop));
    check_eq("sat_busy", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
